// File: rtl/vga_timing_if.sv
// Raster timing bundle between vga_timing_gen (master) and the pixel
// pipeline / framebuffer read logic (slave).
interface vga_timing_if #(
   parameter int unsigned CW  = 12,
   parameter int unsigned FCW = 8
);
   logic           pix_en;
   logic           resync;
   logic [CW-1:0]  pix_x;
   logic [CW-1:0]  pix_y;
   logic           h_sync;
   logic           v_sync;
   logic           draw_active;
   logic           line_start;
   logic           frame_start;
   logic           draw_end;
   logic           screen_end;
   logic [FCW-1:0] frame_cnt;

   modport master (
      input  pix_en, resync,
      output pix_x, pix_y, h_sync, v_sync, draw_active,
      output line_start, frame_start, draw_end, screen_end, frame_cnt
   );

   modport slave (
      output pix_en, resync,
      input  pix_x, pix_y, h_sync, v_sync, draw_active,
      input  line_start, frame_start, draw_end, screen_end, frame_cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, draw qualifier, pixel coordinates,
// line/frame strobes and a wrapping frame counter, advanced by a pixel-clock enable.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE   = 800,
   parameter int unsigned H_FRONT    = 56,
   parameter int unsigned H_SYNC     = 120,
   parameter int unsigned H_BACK     = 64,
   parameter int unsigned V_ACTIVE   = 600,
   parameter int unsigned V_FRONT    = 37,
   parameter int unsigned V_SYNC     = 6,
   parameter int unsigned V_BACK     = 23,
   parameter bit          H_SYNC_POL = 1'b1,
   parameter bit          V_SYNC_POL = 1'b1,
   parameter int unsigned CW         = 12,
   parameter int unsigned FCW        = 8
) (
   input logic          clk,
   input logic          rst,
   vga_timing_if.master vga
);
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_DRAW_LAST = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] V_DRAW_LAST = CW'(V_ACTIVE - 1);

   typedef enum logic [1:0] {PhActive, PhFront, PhSync, PhBack} phase_e;

   function automatic phase_e decode_phase(input logic [CW-1:0] cnt, input int unsigned act,
                                           input int unsigned front, input int unsigned sync);
      if (cnt < CW'(act)) return PhActive;
      if (cnt < CW'(act + front)) return PhFront;
      if (cnt < CW'(act + front + sync)) return PhSync;
      return PhBack;
   endfunction

   logic [CW-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   phase_e         h_phase_q, h_phase_d, v_phase_q, v_phase_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
   logic [CW-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic           h_sync_q, h_sync_d, v_sync_q, v_sync_d;
   logic           draw_active_q, draw_active_d;
   logic           line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic           draw_end_q, draw_end_d, screen_end_q, screen_end_d;

   // Position presented on this tick; resync substitutes (0,0) so the raster
   // restarts immediately and carries on from (1,0).
   logic [CW-1:0] pos_h, pos_v;
   phase_e        pos_hph, pos_vph;
   logic          h_last, v_last;

   always_comb begin
      pos_h   = vga.resync ? '0 : h_cnt_q;
      pos_v   = vga.resync ? '0 : v_cnt_q;
      pos_hph = vga.resync ? PhActive : h_phase_q;
      pos_vph = vga.resync ? PhActive : v_phase_q;
      h_last  = (pos_h == H_LAST);
      v_last  = (pos_v == V_LAST);

      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      h_phase_d     = h_phase_q;
      v_phase_d     = v_phase_q;
      frame_cnt_d   = frame_cnt_q;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      h_sync_d      = h_sync_q;
      v_sync_d      = v_sync_q;
      draw_active_d = draw_active_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      draw_end_d    = 1'b0;
      screen_end_d  = 1'b0;

      if (vga.pix_en) begin
         draw_active_d = (pos_hph == PhActive) && (pos_vph == PhActive);
         pix_x_d       = draw_active_d ? pos_h : '0;
         pix_y_d       = draw_active_d ? pos_v : '0;
         h_sync_d      = (pos_hph == PhSync) ? H_SYNC_POL : ~H_SYNC_POL;
         v_sync_d      = (pos_vph == PhSync) ? V_SYNC_POL : ~V_SYNC_POL;
         line_start_d  = (pos_h == '0);
         frame_start_d = (pos_h == '0) && (pos_v == '0);
         draw_end_d    = (pos_h == H_DRAW_LAST) && (pos_v == V_DRAW_LAST);
         screen_end_d  = h_last && v_last;

         h_cnt_d = h_last ? '0 : pos_h + CW'(1);
         if (h_last) begin
            v_cnt_d = v_last ? '0 : pos_v + CW'(1);
         end else begin
            v_cnt_d = pos_v;
         end
         h_phase_d = decode_phase(h_cnt_d, H_ACTIVE, H_FRONT, H_SYNC);
         v_phase_d = decode_phase(v_cnt_d, V_ACTIVE, V_FRONT, V_SYNC);

         if (h_last && v_last) begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         h_phase_q     <= PhActive;
         v_phase_q     <= PhActive;
         frame_cnt_q   <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         h_sync_q      <= ~H_SYNC_POL;
         v_sync_q      <= ~V_SYNC_POL;
         draw_active_q <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         draw_end_q    <= 1'b0;
         screen_end_q  <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         h_phase_q     <= h_phase_d;
         v_phase_q     <= v_phase_d;
         frame_cnt_q   <= frame_cnt_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         draw_active_q <= draw_active_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         draw_end_q    <= draw_end_d;
         screen_end_q  <= screen_end_d;
      end
   end

   assign vga.pix_x       = pix_x_q;
   assign vga.pix_y       = pix_y_q;
   assign vga.h_sync      = h_sync_q;
   assign vga.v_sync      = v_sync_q;
   assign vga.draw_active = draw_active_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;
   assign vga.draw_end    = draw_end_q;
   assign vga.screen_end  = screen_end_q;
   assign vga.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a 16x8 raster mode: an active-high-sync instance
// (FCW 8) and an active-low-sync instance (FCW 2) share one stimulus stream.
module tb_vga_timing_gen;
   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
      logic       hs;
      logic       vs;
      logic       da;
      logic       ls;
      logic       fs;
      logic       de;
      logic       se;
      logic [7:0] fc;
   } obs_t;

   logic clk, rst, pix_en, resync;
   int   checks, errors;
   obs_t sb_q[$];
   obs_t m_out;
   int   m_h, m_v, m_fc;

   vga_timing_if #(.CW(4), .FCW(8)) if_a ();
   vga_timing_if #(.CW(4), .FCW(2)) if_b ();

   assign if_a.pix_en = pix_en;
   assign if_a.resync = resync;
   assign if_b.pix_en = pix_en;
   assign if_b.resync = resync;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(4), .FCW(8)
   ) u_dut_a (
      .clk(clk),
      .rst(rst),
      .vga(if_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CW(4), .FCW(2)
   ) u_dut_b (
      .clk(clk),
      .rst(rst),
      .vga(if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: model the expected outputs, queue them, clock, then pop and compare.
   task automatic tick(input logic pe, input logic rs, input logic rn);
      obs_t e, got_a, got_b, exp_b;
      pix_en = pe;
      resync = rs;
      rst    = rn;
      e      = m_out;
      e.ls   = 1'b0;
      e.fs   = 1'b0;
      e.de   = 1'b0;
      e.se   = 1'b0;
      if (!rn) begin
         m_h  = 0;
         m_v  = 0;
         m_fc = 0;
         e    = '0;
      end else if (pe) begin
         if (rs) begin
            m_h = 0;
            m_v = 0;
         end
         e.da = (m_h < 8) && (m_v < 4);
         e.x  = e.da ? 4'(m_h) : 4'd0;
         e.y  = e.da ? 4'(m_v) : 4'd0;
         e.hs = (m_h >= 10) && (m_h <= 12);
         e.vs = (m_v >= 5) && (m_v <= 6);
         e.ls = (m_h == 0);
         e.fs = (m_h == 0) && (m_v == 0);
         e.de = (m_h == 7) && (m_v == 3);
         e.se = (m_h == 15) && (m_v == 7);
         if (e.se) m_fc = m_fc + 1;
         e.fc = 8'(m_fc);
         m_h = m_h + 1;
         if (m_h == 16) begin
            m_h = 0;
            m_v = (m_v == 7) ? 0 : m_v + 1;
         end
      end
      m_out = e;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e     = sb_q.pop_front();
      got_a = {if_a.pix_x, if_a.pix_y, if_a.h_sync, if_a.v_sync, if_a.draw_active,
               if_a.line_start, if_a.frame_start, if_a.draw_end, if_a.screen_end,
               if_a.frame_cnt};
      got_b = {if_b.pix_x, if_b.pix_y, ~if_b.h_sync, ~if_b.v_sync, if_b.draw_active,
               if_b.line_start, if_b.frame_start, if_b.draw_end, if_b.screen_end,
               6'd0, if_b.frame_cnt};
      exp_b = e;
      exp_b.fc = {6'd0, e.fc[1:0]};
      checks++;
      if (got_a !== e) begin
         errors++;
         $display("FAIL sb_dut_a @%0t: got %h want %h", $time, got_a, e);
      end
      checks++;
      if (got_b !== exp_b) begin
         errors++;
         $display("FAIL sb_dut_b @%0t: got %h want %h", $time, got_b, exp_b);
      end
   endtask

   task automatic do_reset();
      tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      checks++;
      if (if_a.h_sync !== 1'b0 || if_a.v_sync !== 1'b0) begin
         errors++;
         $display("FAIL reset_sync_a: got %b%b want 00", if_a.h_sync, if_a.v_sync);
      end
      checks++;
      if (if_b.h_sync !== 1'b1 || if_b.v_sync !== 1'b1) begin
         errors++;
         $display("FAIL reset_sync_b_idle_high: got %b%b want 11", if_b.h_sync, if_b.v_sync);
      end
      checks++;
      if (if_a.draw_active !== 1'b0 || if_a.frame_cnt !== 8'd0 || if_a.frame_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_levels: got da=%b fc=%0d fs=%b want 0 0 0",
                  if_a.draw_active, if_a.frame_cnt, if_a.frame_start);
      end
   endtask

   task automatic test_small_mode();
      int da_n, hs_n, vs_n, hsb_low_n;
      logic [3:0] x7, x8;
      da_n = 0; hs_n = 0; vs_n = 0; hsb_low_n = 0; x7 = '0; x8 = '1;
      do_reset();
      for (int t = 0; t < 128; t++) begin
         tick(1'b1, 1'b0, 1'b1);
         if (if_a.draw_active) da_n++;
         if (if_a.h_sync) hs_n++;
         if (if_a.v_sync) vs_n++;
         if (!if_b.h_sync) hsb_low_n++;
         if (t == 7) x7 = if_a.pix_x;
         if (t == 8) x8 = if_a.pix_x;
      end
      checks++;
      if (da_n != 32) begin
         errors++;
         $display("FAIL small_draw_active_ticks: got %0d want 32", da_n);
      end
      checks++;
      if (hs_n != 24) begin
         errors++;
         $display("FAIL small_hsync_ticks: got %0d want 24", hs_n);
      end
      checks++;
      if (vs_n != 32) begin
         errors++;
         $display("FAIL small_vsync_ticks: got %0d want 32", vs_n);
      end
      checks++;
      if (hsb_low_n != 24) begin
         errors++;
         $display("FAIL neg_pol_hsync_low_ticks: got %0d want 24", hsb_low_n);
      end
      checks++;
      if (x7 !== 4'd7 || x8 !== 4'd0) begin
         errors++;
         $display("FAIL small_pix_x_wrap: got %0d,%0d want 7,0", x7, x8);
      end
   endtask

   task automatic test_two_frames();
      int fs_idx[$], se_idx[$], se_fc[$], de_first;
      de_first = -1;
      do_reset();
      for (int t = 0; t < 256; t++) begin
         tick(1'b1, 1'b0, 1'b1);
         if (if_a.frame_start) fs_idx.push_back(t);
         if (if_a.screen_end) begin
            se_idx.push_back(t);
            se_fc.push_back(int'(if_a.frame_cnt));
         end
         if (if_a.draw_end && de_first < 0) de_first = t;
      end
      checks++;
      if (fs_idx.size() != 2 || fs_idx[0] != 0 || fs_idx[1] != 128) begin
         errors++;
         $display("FAIL frame_start_ticks: got n=%0d want ticks 0,128", fs_idx.size());
      end
      checks++;
      if (se_idx.size() != 2 || se_idx[0] != 127 || se_idx[1] != 255) begin
         errors++;
         $display("FAIL screen_end_ticks: got n=%0d want ticks 127,255", se_idx.size());
      end
      checks++;
      if (se_fc.size() != 2 || se_fc[0] != 1 || se_fc[1] != 2) begin
         errors++;
         $display("FAIL frame_cnt_at_screen_end: got n=%0d want 1,2", se_fc.size());
      end
      checks++;
      if (de_first != 55) begin
         errors++;
         $display("FAIL draw_end_tick: got %0d want 55", de_first);
      end
   endtask

   task automatic test_sparse();
      int ls_n, se_n, hold_bad, fs_c[$];
      logic [3:0] px_prev;
      logic       hs_prev;
      ls_n = 0; se_n = 0; hold_bad = 0;
      do_reset();
      px_prev = if_a.pix_x;
      hs_prev = if_a.h_sync;
      for (int c = 0; c < 768; c++) begin
         tick((c % 3) == 0, 1'b0, 1'b1);
         if (if_a.line_start) ls_n++;
         if (if_a.screen_end) se_n++;
         if (if_a.frame_start) fs_c.push_back(c);
         if ((c % 3) != 0 && (if_a.pix_x !== px_prev || if_a.h_sync !== hs_prev)) hold_bad++;
         px_prev = if_a.pix_x;
         hs_prev = if_a.h_sync;
      end
      checks++;
      if (ls_n != 16) begin
         errors++;
         $display("FAIL sparse_line_start_cycles: got %0d want 16", ls_n);
      end
      checks++;
      if (se_n != 2) begin
         errors++;
         $display("FAIL sparse_screen_end_cycles: got %0d want 2", se_n);
      end
      checks++;
      if (fs_c.size() != 2 || (fs_c[1] - fs_c[0]) != 384) begin
         errors++;
         $display("FAIL sparse_frame_period: got n=%0d want 2 strobes 384 clk apart",
                  fs_c.size());
      end
      checks++;
      if (hold_bad != 0) begin
         errors++;
         $display("FAIL sparse_level_hold: got %0d changes want 0", hold_bad);
      end
   endtask

   task automatic test_resync();
      do_reset();
      for (int t = 0; t < 128 + 37; t++) tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b1);
      checks++;
      if (if_a.pix_x !== 4'd0 || if_a.pix_y !== 4'd0 || if_a.frame_start !== 1'b1 ||
          if_a.line_start !== 1'b1) begin
         errors++;
         $display("FAIL resync_origin: got x=%0d y=%0d fs=%b ls=%b want 0 0 1 1",
                  if_a.pix_x, if_a.pix_y, if_a.frame_start, if_a.line_start);
      end
      checks++;
      if (if_a.frame_cnt !== 8'd1) begin
         errors++;
         $display("FAIL resync_frame_cnt: got %0d want 1", if_a.frame_cnt);
      end
      for (int t = 0; t < 3; t++) tick(1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b1, 1'b1);
      checks++;
      if (if_a.pix_x !== 4'd3 || if_a.frame_start !== 1'b0) begin
         errors++;
         $display("FAIL resync_ignored_idle: got x=%0d fs=%b want 3 0",
                  if_a.pix_x, if_a.frame_start);
      end
      tick(1'b1, 1'b0, 1'b1);
      checks++;
      if (if_a.pix_x !== 4'd4) begin
         errors++;
         $display("FAIL resync_ignored_continue: got x=%0d want 4", if_a.pix_x);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int t = 0; t < 128 + 109; t++) tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      checks++;
      if (if_a.h_sync !== 1'b0 || if_a.v_sync !== 1'b0 || if_a.frame_cnt !== 8'd0 ||
          if_a.pix_x !== 4'd0 || if_a.draw_active !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_values: got hs=%b vs=%b fc=%0d x=%0d da=%b want 0 0 0 0 0",
                  if_a.h_sync, if_a.v_sync, if_a.frame_cnt, if_a.pix_x, if_a.draw_active);
      end
      tick(1'b1, 1'b0, 1'b1);
      checks++;
      if (if_a.frame_start !== 1'b1 || if_a.pix_x !== 4'd0 || if_a.pix_y !== 4'd0) begin
         errors++;
         $display("FAIL mid_reset_restart: got fs=%b x=%0d y=%0d want 1 0 0",
                  if_a.frame_start, if_a.pix_x, if_a.pix_y);
      end
   endtask

   task automatic test_wrap();
      int fcb[$];
      do_reset();
      for (int t = 0; t < 512; t++) begin
         tick(1'b1, 1'b0, 1'b1);
         if (if_b.screen_end) fcb.push_back(int'(if_b.frame_cnt));
      end
      checks++;
      if (fcb.size() != 4 || fcb[2] != 3 || fcb[3] != 0) begin
         errors++;
         $display("FAIL fcw2_wrap: got n=%0d want sequence 1,2,3,0", fcb.size());
      end
      checks++;
      if (if_a.frame_cnt !== 8'd4) begin
         errors++;
         $display("FAIL fcw8_count: got %0d want 4", if_a.frame_cnt);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_h = 0; m_v = 0; m_fc = 0;
      m_out = '0;
      test_reset();
      test_small_mode();
      test_two_frames();
      test_sparse();
      test_resync();
      test_reset_mid();
      test_wrap();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
